// File: rtl/axi4s_pkg.sv
// Shared constants and elaboration helpers for the AXI4-Stream FIFO read adapter.
// Contents: level-width function, maximum supported FIFO read latency,
// and the parameter legality check evaluated at elaboration.
package axi4s_pkg;

  localparam int unsigned MAX_RD_LAT = 2;

  // Width needed to hold an occupancy count of 0..depth.
  function automatic int unsigned level_w(input int unsigned depth);
    return int'($clog2(depth + 1));
  endfunction

  // Data width >= 1, read latency within range, buffer depth a power of two >= 2.
  function automatic bit params_ok(input int unsigned dlen,
                                   input int unsigned rd_lat,
                                   input int unsigned depth);
    return (dlen >= 1) && (rd_lat <= MAX_RD_LAT) && (depth >= 2) &&
           ((depth & (depth - 1)) == 0);
  endfunction

endpackage

// File: rtl/axi4s_obuf.sv
// Circular register buffer holding prefetched FIFO words.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   push_i/wdata_i write one entry at the tail
//   pop_i          retire the head entry (ignored when empty)
//   valid_o        registered "buffer not empty"
//   head_o         entry at the read pointer
//   occ_o          registered occupancy
module axi4s_obuf
  import axi4s_pkg::*;
#(
  parameter int unsigned W     = 32,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned LW    = level_w(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic [W-1:0]  wdata_i,
  input  logic          pop_i,
  output logic          valid_o,
  output logic [W-1:0]  head_o,
  output logic [LW-1:0] occ_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] occ_q, occ_d;
  logic          valid_q, valid_d;
  logic          pop;

  // Pointer / occupancy next state; pointers wrap naturally (power-of-two depth).
  always_comb begin
    pop      = pop_i & valid_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (push_i) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)    rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push_i, pop})
      2'b10:   occ_d = occ_q + LW'(1);
      2'b01:   occ_d = occ_q - LW'(1);
      default: occ_d = occ_q;
    endcase
    valid_d = (occ_d != '0);
  end

  // State and storage; storage is cleared so the head reads zero out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      valid_q  <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      valid_q  <= valid_d;
      if (push_i) mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  // Credit accounting upstream must never push into a full buffer without a pop.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(push_i && !pop && (occ_q == LW'(DEPTH))));
    end
  end

  assign valid_o = valid_q;
  assign head_o  = mem_q[rd_ptr_q];
  assign occ_o   = occ_q;

endmodule

// File: rtl/axi4s_fifo_rd_prefetch.sv
// Read-side AXI4-Stream master adapter: issues speculative FIFO reads against
// a credit budget and streams returned words from a prefetch buffer.
// Optional feature macro: AXI4S_RD_TLAST_EN (adds i_rlast / m_tlast).
// Ports:
//   clk, rst                clock, synchronous active-high reset
//   o_ren                   FIFO pop (combinational)
//   i_rdata, i_rempty       FIFO read data (RD_LAT after o_ren), empty flag
//   i_rlast, m_tlast        packet-end marker in / out (macro only)
//   m_tvalid/m_tready/m_tdata  AXI4-Stream master
//   o_level                 prefetch buffer occupancy
module axi4s_fifo_rd_prefetch
  import axi4s_pkg::*;
#(
  parameter int unsigned DLEN       = 32,
  parameter int unsigned RD_LAT     = 1,
  parameter int unsigned OBUF_DEPTH = 4
) (
  input  logic                                clk,
  input  logic                                rst,
  output logic                                o_ren,
  input  logic [DLEN-1:0]                     i_rdata,
  input  logic                                i_rempty,
`ifdef AXI4S_RD_TLAST_EN
  input  logic                                i_rlast,
  output logic                                m_tlast,
`endif
  output logic                                m_tvalid,
  input  logic                                m_tready,
  output logic [DLEN-1:0]                     m_tdata,
  output logic [level_w(OBUF_DEPTH)-1:0]      o_level
);

  localparam int unsigned LW = level_w(OBUF_DEPTH);
`ifdef AXI4S_RD_TLAST_EN
  localparam int unsigned TL_W = 1;
`else
  localparam int unsigned TL_W = 0;
`endif
  localparam int unsigned W = DLEN + TL_W;

  if (!params_ok(DLEN, RD_LAT, OBUF_DEPTH)) begin : g_bad_params
    $error("axi4s_fifo_rd_prefetch: illegal DLEN/RD_LAT/OBUF_DEPTH");
  end

  logic          push;
  logic [LW-1:0] infl_cnt;
  logic [LW-1:0] occ;
  logic [LW-1:0] budget;
  logic [W-1:0]  wdata;
  logic [W-1:0]  head;

  // Credit from registered state only: a same-cycle pop does not free a slot.
  assign budget = LW'(OBUF_DEPTH) - occ - infl_cnt;
  assign o_ren  = ~i_rempty & (budget != '0) & ~rst;

  if (RD_LAT == 0) begin : g_fwft
    // First-word-fall-through: data is already on i_rdata when popping.
    assign push     = o_ren;
    assign infl_cnt = '0;
  end else begin : g_infl
    // One bit per outstanding read; the tail bit marks data arriving this cycle.
    logic [RD_LAT-1:0] infl_q, infl_d;

    assign infl_d = RD_LAT'({infl_q, o_ren});

    always_ff @(posedge clk) begin
      if (rst) infl_q <= '0;
      else     infl_q <= infl_d;
    end

    assign push     = infl_q[RD_LAT-1];
    assign infl_cnt = LW'($countones(infl_q));
  end

`ifdef AXI4S_RD_TLAST_EN
  assign wdata   = {i_rlast, i_rdata};
  assign m_tlast = head[DLEN];
`else
  assign wdata   = i_rdata;
`endif

  axi4s_obuf #(
    .W     (W),
    .DEPTH (OBUF_DEPTH),
    .LW    (LW)
  ) u_obuf (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .wdata_i (wdata),
    .pop_i   (m_tvalid & m_tready),
    .valid_o (m_tvalid),
    .head_o  (head),
    .occ_o   (occ)
  );

  assign m_tdata = head[DLEN-1:0];
  assign o_level = occ;

endmodule

// File: tb/tb_axi4s_fifo_rd_prefetch.sv
// Bench for axi4s_fifo_rd_prefetch: three instances (RD_LAT 0/1/2, depth 4)
// share one word source and one m_tready; each has its own FIFO read model
// and expected-word queue.
module tb_axi4s_fifo_rd_prefetch;
  import axi4s_pkg::*;

  localparam int unsigned DLEN  = 32;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned LW    = level_w(DEPTH);
  localparam int          NI    = 3;

  logic clk = 1'b0;
  logic rst;
  logic tready;

  logic            ren0, ren1, ren2;
  logic [DLEN-1:0] rdata0, rdata1, rdata2;
  logic            empty0, empty1, empty2;
  logic            valid0, valid1, valid2;
  logic [DLEN-1:0] data0, data1, data2;
  logic [LW-1:0]   lvl0, lvl1, lvl2;
`ifdef AXI4S_RD_TLAST_EN
  logic            rlast0, rlast1, rlast2;
  logic            tlast0, tlast1, tlast2;
  assign rlast0 = (rdata0 == 32'd7);
  assign rlast1 = (rdata1 == 32'd7);
  assign rlast2 = (rdata2 == 32'd7);
`endif

  logic [DLEN-1:0] src [256];
  int              src_n;
  int              ridx0, ridx1, ridx2;
  logic [DLEN-1:0] p1, p2a, p2b;
  logic [DLEN-1:0] sb0 [$];
  logic [DLEN-1:0] sb1 [$];
  logic [DLEN-1:0] sb2 [$];
  int              n_cmp, n_bad;

  logic            s_ren   [NI];
  logic            s_valid [NI];
  logic [DLEN-1:0] s_data  [NI];
  logic [LW-1:0]   s_lvl   [NI];
  logic            s_last  [NI];
  logic            prev_stall [NI];
  logic [DLEN-1:0] prev_data  [NI];

  always #5 clk = ~clk;

  // FIFO models: lat0 is fall-through, lat1/lat2 return data 1/2 cycles after pop.
  assign empty0 = (ridx0 >= src_n);
  assign empty1 = (ridx1 >= src_n);
  assign empty2 = (ridx2 >= src_n);
  assign rdata0 = src[ridx0[7:0]];
  assign rdata1 = p1;
  assign rdata2 = p2b;

  always @(posedge clk) begin
    if (rst) begin
      ridx0 <= 0; ridx1 <= 0; ridx2 <= 0;
      p1 <= '0; p2a <= '0; p2b <= '0;
    end else begin
      if (ren0) ridx0 <= ridx0 + 1;
      if (ren1) begin p1  <= src[ridx1[7:0]]; ridx1 <= ridx1 + 1; end
      if (ren2) begin p2a <= src[ridx2[7:0]]; ridx2 <= ridx2 + 1; end
      p2b <= p2a;
    end
  end

  axi4s_fifo_rd_prefetch #(.DLEN(DLEN), .RD_LAT(0), .OBUF_DEPTH(DEPTH)) u_lat0 (
    .clk(clk), .rst(rst), .o_ren(ren0), .i_rdata(rdata0), .i_rempty(empty0),
`ifdef AXI4S_RD_TLAST_EN
    .i_rlast(rlast0), .m_tlast(tlast0),
`endif
    .m_tvalid(valid0), .m_tready(tready), .m_tdata(data0), .o_level(lvl0));

  axi4s_fifo_rd_prefetch #(.DLEN(DLEN), .RD_LAT(1), .OBUF_DEPTH(DEPTH)) u_lat1 (
    .clk(clk), .rst(rst), .o_ren(ren1), .i_rdata(rdata1), .i_rempty(empty1),
`ifdef AXI4S_RD_TLAST_EN
    .i_rlast(rlast1), .m_tlast(tlast1),
`endif
    .m_tvalid(valid1), .m_tready(tready), .m_tdata(data1), .o_level(lvl1));

  axi4s_fifo_rd_prefetch #(.DLEN(DLEN), .RD_LAT(2), .OBUF_DEPTH(DEPTH)) u_lat2 (
    .clk(clk), .rst(rst), .o_ren(ren2), .i_rdata(rdata2), .i_rempty(empty2),
`ifdef AXI4S_RD_TLAST_EN
    .i_rlast(rlast2), .m_tlast(tlast2),
`endif
    .m_tvalid(valid2), .m_tready(tready), .m_tdata(data2), .o_level(lvl2));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_word(input logic [DLEN-1:0] w);
    src[src_n[7:0]] = w;
    src_n++;
    sb0.push_back(w);
    sb1.push_back(w);
    sb2.push_back(w);
  endtask

  // One clock cycle: sample at the falling edge, score handshakes, return just after the rising edge.
  task automatic step();
    logic [DLEN-1:0] exp;
    int              pend;
    @(negedge clk);
    s_ren[0] = ren0;     s_ren[1] = ren1;     s_ren[2] = ren2;
    s_valid[0] = valid0; s_valid[1] = valid1; s_valid[2] = valid2;
    s_data[0] = data0;   s_data[1] = data1;   s_data[2] = data2;
    s_lvl[0] = lvl0;     s_lvl[1] = lvl1;     s_lvl[2] = lvl2;
`ifdef AXI4S_RD_TLAST_EN
    s_last[0] = tlast0;  s_last[1] = tlast1;  s_last[2] = tlast2;
`else
    s_last[0] = 1'b0;    s_last[1] = 1'b0;    s_last[2] = 1'b0;
`endif
    for (int k = 0; k < NI; k++) begin
      if (prev_stall[k] && !rst) begin
        chk($sformatf("lat%0d valid held", k), 32'(s_valid[k]), 32'd1);
        chk($sformatf("lat%0d data held", k), s_data[k], prev_data[k]);
      end
`ifdef AXI4S_RD_TLAST_EN
      if (s_valid[k] && !rst)
        chk($sformatf("lat%0d tlast", k), 32'(s_last[k]), 32'(s_data[k] == 32'd7));
`endif
      if (s_valid[k] && tready && !rst) begin
        pend = (k == 0) ? sb0.size() : (k == 1) ? sb1.size() : sb2.size();
        chk($sformatf("lat%0d beat has expected word", k), 32'(pend != 0), 32'd1);
        if (pend != 0) begin
          case (k)
            0:       exp = sb0.pop_front();
            1:       exp = sb1.pop_front();
            default: exp = sb2.pop_front();
          endcase
          chk($sformatf("lat%0d beat data", k), s_data[k], exp);
        end
      end
      prev_stall[k] = s_valid[k] && !tready && !rst;
      prev_data[k]  = s_data[k];
    end
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic       tready;
    logic [2:0] ren;    // bit k = instance lat k
    logic [2:0] valid;
    int         lvl0, lvl1, lvl2;
  } vec_t;

  vec_t tbl [6];
  int   ren_cnt [NI];
  int   first_v [NI];
  int   last_v  [NI];
  int   nbeat   [NI];
  int   lv;

  initial begin
    n_cmp = 0; n_bad = 0; src_n = 0;
    rst = 1'b1; tready = 1'b0;
    for (int k = 0; k < NI; k++) begin prev_stall[k] = 1'b0; prev_data[k] = '0; end

    // Word 0x11 one pop away, m_tready low, word held in the buffer until released.
    tbl[0] = '{1'b0, 3'b111, 3'b000, 0, 0, 0};
    tbl[1] = '{1'b0, 3'b000, 3'b001, 1, 0, 0};
    tbl[2] = '{1'b0, 3'b000, 3'b011, 1, 1, 0};
    tbl[3] = '{1'b0, 3'b000, 3'b111, 1, 1, 1};
    tbl[4] = '{1'b1, 3'b000, 3'b111, 1, 1, 1};
    tbl[5] = '{1'b1, 3'b000, 3'b000, 0, 0, 0};

    // Reset with a non-empty FIFO: everything stays quiet.
    push_word(32'h11);
    repeat (3) begin
      step();
      for (int k = 0; k < NI; k++) begin
        chk($sformatf("rst lat%0d o_ren", k), 32'(s_ren[k]), 32'd0);
        chk($sformatf("rst lat%0d m_tvalid", k), 32'(s_valid[k]), 32'd0);
        chk($sformatf("rst lat%0d m_tdata", k), s_data[k], 32'd0);
        chk($sformatf("rst lat%0d o_level", k), 32'(s_lvl[k]), 32'd0);
      end
    end
    rst = 1'b0;

    // Pass 0: reset release; pass 1: i_rempty falls on an idle adapter.
    for (int pass = 0; pass < 2; pass++) begin
      if (pass == 1) push_word(32'h11);
      for (int i = 0; i < 6; i++) begin
        tready = tbl[i].tready;
        step();
        for (int k = 0; k < NI; k++) begin
          lv = (k == 0) ? tbl[i].lvl0 : (k == 1) ? tbl[i].lvl1 : tbl[i].lvl2;
          chk($sformatf("lat p%0d v%0d lat%0d o_ren", pass, i, k), 32'(s_ren[k]), 32'(tbl[i].ren[k]));
          chk($sformatf("lat p%0d v%0d lat%0d m_tvalid", pass, i, k), 32'(s_valid[k]), 32'(tbl[i].valid[k]));
          chk($sformatf("lat p%0d v%0d lat%0d o_level", pass, i, k), 32'(s_lvl[k]), 32'(lv));
        end
      end
    end

    // Streaming: 16 words, ready held high, one beat per cycle after the first.
    tready = 1'b1;
    for (int w = 0; w < 16; w++) push_word(32'(w));
    for (int k = 0; k < NI; k++) begin first_v[k] = -1; last_v[k] = -1; nbeat[k] = 0; end
    for (int c = 0; c < 30; c++) begin
      step();
      for (int k = 0; k < NI; k++) begin
        if (s_valid[k]) begin
          if (first_v[k] < 0) first_v[k] = c;
          last_v[k] = c;
          nbeat[k]++;
        end
      end
    end
    for (int k = 0; k < NI; k++) begin
      chk($sformatf("stream lat%0d beats", k), 32'(nbeat[k]), 32'd16);
      chk($sformatf("stream lat%0d span", k), 32'(last_v[k] - first_v[k] + 1), 32'd16);
      chk($sformatf("stream lat%0d first-beat latency", k), 32'(first_v[k]), 32'(k + 1));
    end

    // Back-pressure on a full FIFO: exactly DEPTH reads, buffer full, head held.
    tready = 1'b0;
    for (int w = 0; w < 8; w++) push_word(32'h100 + 32'(w));
    for (int k = 0; k < NI; k++) ren_cnt[k] = 0;
    repeat (10) begin
      step();
      for (int k = 0; k < NI; k++) ren_cnt[k] += int'(s_ren[k]);
    end
    for (int k = 0; k < NI; k++) begin
      chk($sformatf("bp lat%0d o_ren pulses", k), 32'(ren_cnt[k]), 32'd4);
      chk($sformatf("bp lat%0d o_level", k), 32'(s_lvl[k]), 32'd4);
      chk($sformatf("bp lat%0d head word", k), s_data[k], 32'h100);
    end
    tready = 1'b1;
    step();
    for (int k = 0; k < NI; k++)
      chk($sformatf("bp release lat%0d o_level", k), 32'(s_lvl[k]), 32'd4);
    repeat (15) step();
    chk("bp lat0 drained", 32'(sb0.size()), 32'd0);
    chk("bp lat1 drained", 32'(sb1.size()), 32'd0);
    chk("bp lat2 drained", 32'(sb2.size()), 32'd0);
    for (int k = 0; k < NI; k++)
      chk($sformatf("bp lat%0d empty level", k), 32'(s_lvl[k]), 32'd0);

    // Mid-operation reset discards buffered and in-flight words (FIFO reset too).
    tready = 1'b0;
    for (int w = 0; w < 6; w++) push_word(32'h200 + 32'(w));
    repeat (3) step();
    rst = 1'b1;
    src_n = 0;
    sb0.delete(); sb1.delete(); sb2.delete();
    step();
    for (int k = 0; k < NI; k++)
      chk($sformatf("midrst lat%0d o_ren", k), 32'(s_ren[k]), 32'd0);
    step();
    for (int k = 0; k < NI; k++) begin
      chk($sformatf("midrst lat%0d m_tvalid", k), 32'(s_valid[k]), 32'd0);
      chk($sformatf("midrst lat%0d m_tdata", k), s_data[k], 32'd0);
      chk($sformatf("midrst lat%0d o_level", k), 32'(s_lvl[k]), 32'd0);
    end
    rst = 1'b0;
    tready = 1'b1;
    for (int w = 0; w < 4; w++) push_word(32'h300 + 32'(w));
    repeat (12) step();
    chk("midrst lat0 drained", 32'(sb0.size()), 32'd0);
    chk("midrst lat1 drained", 32'(sb1.size()), 32'd0);
    chk("midrst lat2 drained", 32'(sb2.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
